seq_detect_ctrl: RTL and testbench

//   Controller for run-length sequence detection on serial input W (runs of N zeros and/or ones).

---
 rtl/seq_ctrl_pkg.sv | 31 +++
 rtl/seq_run_tracker.sv | 61 ++++++
 rtl/seq_detect_ctrl.sv | 168 ++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - shared state/mode encodings and helpers for the run-length detect controller
package seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // Mode bit 1 set means "either polarity"; bit 0 is then don't-care.
    localparam logic [1:0] MODE_ZERO = 2'b00;
    localparam logic [1:0] MODE_ONE  = 2'b01;
    localparam logic [1:0] MODE_ANY  = 2'b10;

    // A run of one bit is every sample, so shorter lengths are promoted.
    localparam int MIN_RUN_LEN = 2;

    function automatic logic mode_allows(input logic [1:0] mode, input logic bit_v);
        logic ok;
        if ((mode & MODE_ANY) != 2'b00) begin
            ok = 1'b1;
        end else begin
            case (mode)
                MODE_ZERO: ok = ~bit_v;
                MODE_ONE:  ok = bit_v;
                default:   ok = 1'b1;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/seq_run_tracker.sv
// rtl/seq_run_tracker.sv - last-bit / saturating run counter with one detect per run
module seq_run_tracker #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic             w,
    input  logic [LEN_W-1:0] n,
    output logic             detect,
    output logic             bit_o
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic             has_last_q, has_last_d;
    logic             last_q, last_d;
    logic [LEN_W-1:0] run_q, run_d;

    // Next run state; detect fires only on the N-1 -> N step so a saturated run never retriggers.
    always_comb begin
        has_last_d = has_last_q;
        last_d     = last_q;
        run_d      = run_q;
        detect     = 1'b0;
        bit_o      = w;
        if (clear) begin
            has_last_d = 1'b0;
            last_d     = 1'b0;
            run_d      = '0;
        end else if (en) begin
            has_last_d = 1'b1;
            last_d     = w;
            if (!has_last_q || (w != last_q)) begin
                run_d = ONE;
            end else begin
                if (run_q != n) begin
                    run_d = run_q + ONE;
                end
                if (run_q == (n - ONE)) begin
                    detect = 1'b1;
                end
            end
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            has_last_q <= 1'b0;
            last_q     <= 1'b0;
            run_q      <= '0;
        end else begin
            has_last_q <= has_last_d;
            last_q     <= last_d;
            run_q      <= run_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - session FSM for run-length event detection with valid/ack hand-off
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int WIN_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             pCLK,
    input  logic             nREST,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_max,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             W,
    input  logic             w_valid,
    output logic             evt_valid,
    output logic             evt_kind,
    input  logic             evt_ack,
    output logic [CNT_W-1:0] evt_count,
    output logic             evt_drop,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_kind_q, evt_kind_d;
    logic [CNT_W-1:0] evt_count_q, evt_count_d;
    logic             evt_drop_q, evt_drop_d;
    logic             timeout_q, timeout_d;

    logic             is_busy;
    logic             start_ok;
    logic             sample;
    logic             trk_detect;
    logic             trk_bit;
    logic             det;
    logic [WIN_W-1:0] win_next;
    logic             win_hit;
    logic             quota_hit;

    assign is_busy   = (state_q == ST_RUN) || (state_q == ST_WAIT_ACK);
    assign start_ok  = cfg_start && !cfg_stop && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign sample    = w_valid && is_busy;
    assign det       = trk_detect && mode_allows(mode_q, trk_bit);
    assign win_next  = win_cnt_q + WIN_W'(1);
    assign win_hit   = sample && (win_q != '0) && (win_next == win_q);
    assign quota_hit = (max_q != '0) && (evt_count_q == max_q);

    seq_run_tracker #(.LEN_W(LEN_W)) u_tracker (
        .clk    (pCLK),
        .rst_n  (nREST),
        .clear  (start_ok),
        .en     (sample),
        .w      (W),
        .n      (len_q),
        .detect (trk_detect),
        .bit_o  (trk_bit)
    );

    // Session FSM; priority is stop, then window expiry, then quota/ack, then detect.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        mode_d      = mode_q;
        max_d       = max_q;
        win_d       = win_q;
        win_cnt_d   = win_cnt_q;
        evt_valid_d = evt_valid_q;
        evt_kind_d  = evt_kind_q;
        evt_count_d = evt_count_q;
        evt_drop_d  = evt_drop_q;
        timeout_d   = timeout_q;

        if (start_ok) begin
            state_d     = ST_RUN;
            len_d       = (cfg_len < LEN_W'(MIN_RUN_LEN)) ? LEN_W'(MIN_RUN_LEN) : cfg_len;
            mode_d      = cfg_mode;
            max_d       = cfg_max;
            win_d       = cfg_window;
            win_cnt_d   = '0;
            evt_valid_d = 1'b0;
            evt_kind_d  = 1'b0;
            evt_count_d = '0;
            evt_drop_d  = 1'b0;
            timeout_d   = 1'b0;
        end else if (cfg_stop) begin
            state_d     = ST_IDLE;
            evt_valid_d = 1'b0;
        end else if (is_busy) begin
            if (sample) begin
                win_cnt_d = win_next;
            end
            if (win_hit) begin
                state_d     = ST_DONE;
                timeout_d   = 1'b1;
                evt_valid_d = 1'b0;
            end else if (state_q == ST_RUN) begin
                if (det) begin
                    state_d     = ST_WAIT_ACK;
                    evt_valid_d = 1'b1;
                    evt_kind_d  = trk_bit;
                    evt_count_d = evt_count_q + CNT_W'(1);
                end
            end else if (evt_ack) begin
                if (quota_hit) begin
                    state_d     = ST_DONE;
                    evt_valid_d = 1'b0;
                end else if (det) begin
                    evt_kind_d  = trk_bit;
                    evt_count_d = evt_count_q + CNT_W'(1);
                end else begin
                    state_d     = ST_RUN;
                    evt_valid_d = 1'b0;
                end
            end else if (det) begin
                evt_drop_d = 1'b1;
            end
        end
    end

    // Session state, latched config and output registers.
    always_ff @(posedge pCLK or negedge nREST) begin
        if (!nREST) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            mode_q      <= '0;
            max_q       <= '0;
            win_q       <= '0;
            win_cnt_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_kind_q  <= 1'b0;
            evt_count_q <= '0;
            evt_drop_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            max_q       <= max_d;
            win_q       <= win_d;
            win_cnt_q   <= win_cnt_d;
            evt_valid_q <= evt_valid_d;
            evt_kind_q  <= evt_kind_d;
            evt_count_q <= evt_count_d;
            evt_drop_q  <= evt_drop_d;
            timeout_q   <= timeout_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_kind  = evt_kind_q;
    assign evt_count = evt_count_q;
    assign evt_drop  = evt_drop_q;
    assign busy      = is_busy;
    assign done      = (state_q == ST_DONE);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

    localparam int LEN_W = 4;
    localparam int WIN_W = 16;
    localparam int CNT_W = 8;

    logic             pclk;
    logic             nrest;
    logic             cfg_start;
    logic             cfg_stop;
    logic [LEN_W-1:0] cfg_len;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_max;
    logic [WIN_W-1:0] cfg_window;
    logic             w;
    logic             w_valid;
    logic             evt_valid;
    logic             evt_kind;
    logic             evt_ack;
    logic [CNT_W-1:0] evt_count;
    logic             evt_drop;
    logic             busy;
    logic             done;
    logic             timeout;

    int n_checks = 0;
    int n_pass   = 0;

    seq_detect_ctrl #(.LEN_W(LEN_W), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .pCLK       (pclk),
        .nREST      (nrest),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_len    (cfg_len),
        .cfg_mode   (cfg_mode),
        .cfg_max    (cfg_max),
        .cfg_window (cfg_window),
        .W          (w),
        .w_valid    (w_valid),
        .evt_valid  (evt_valid),
        .evt_kind   (evt_kind),
        .evt_ack    (evt_ack),
        .evt_count  (evt_count),
        .evt_drop   (evt_drop),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic samp(input logic b);
        w       = b;
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
    endtask

    task automatic start_cfg(input logic [LEN_W-1:0] len, input logic [1:0] mode,
                             input logic [CNT_W-1:0] max, input logic [WIN_W-1:0] win);
        cfg_len    = len;
        cfg_mode   = mode;
        cfg_max    = max;
        cfg_window = win;
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
    endtask

    initial begin
        nrest = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_len = '0; cfg_mode = '0;
        cfg_max = '0; cfg_window = '0; w = 1'b0; w_valid = 1'b0; evt_ack = 1'b0;
        tick(); tick();
        check("rst_valid", evt_valid, 0);
        check("rst_count", evt_count, 0);
        check("rst_busy_done", {busy, done, timeout, evt_drop}, 0);
        nrest = 1'b1;
        tick();

        // N=4, ones only, run of seven ones, ack the single event.
        start_cfg(4'd4, 2'b01, 8'd0, 16'd0);
        check("t2_busy", busy, 1);
        samp(1'b1); samp(1'b1); samp(1'b1);
        check("t2_no_evt_3", evt_valid, 0);
        samp(1'b1);
        check("t2_evt_4", {evt_valid, evt_kind, evt_count}, {1'b1, 1'b1, 8'd1});
        evt_ack = 1'b1;
        samp(1'b1);
        evt_ack = 1'b0;
        check("t2_acked", evt_valid, 0);
        samp(1'b1); samp(1'b1);
        check("t2_one_event", {evt_valid, evt_count, evt_drop}, {1'b0, 8'd1, 1'b0});

        // Asynchronous reset in the middle of a session.
        #2 nrest = 1'b0;
        #1;
        check("t1_async_cnt", evt_count, 0);
        check("t1_async_st", {busy, done, evt_valid, timeout}, 0);
        tick();
        nrest = 1'b1;
        tick();

        // N=4, either polarity, 0000 1111 0000 with ack held, quota 3.
        start_cfg(4'd4, 2'b10, 8'd3, 16'd0);
        evt_ack = 1'b1;
        repeat (4) samp(1'b0);
        check("t3_evt1", {evt_valid, evt_kind, evt_count}, {1'b1, 1'b0, 8'd1});
        repeat (4) samp(1'b1);
        check("t3_evt2", {evt_valid, evt_kind, evt_count}, {1'b1, 1'b1, 8'd2});
        repeat (4) samp(1'b0);
        check("t3_evt3", {evt_valid, evt_kind, evt_count}, {1'b1, 1'b0, 8'd3});
        check("t3_not_done", done, 0);
        tick();
        check("t3_done", {done, busy, timeout, evt_valid}, {1'b1, 1'b0, 1'b0, 1'b0});
        check("t3_count", evt_count, 3);
        evt_ack = 1'b0;
        tick();
        check("t3_hold", {done, evt_count}, {1'b1, 8'd3});

        // N=2, either polarity, 00110011 never acked.
        start_cfg(4'd2, 2'b10, 8'd0, 16'd0);
        check("t4_fresh", {done, evt_count, busy}, {1'b0, 8'd0, 1'b1});
        samp(1'b0); samp(1'b0);
        check("t4_evt1", {evt_valid, evt_kind, evt_count}, {1'b1, 1'b0, 8'd1});
        samp(1'b1);
        check("t4_no_drop_yet", evt_drop, 0);
        samp(1'b1);
        check("t4_drop", evt_drop, 1);
        samp(1'b0); samp(1'b0); samp(1'b1); samp(1'b1);
        check("t4_held", {evt_valid, evt_kind, evt_count, evt_drop}, {1'b1, 1'b0, 8'd1, 1'b1});

        // Stop and start together in WAIT_ACK: stop wins, counters retained.
        cfg_stop = 1'b1; cfg_start = 1'b1;
        tick();
        cfg_stop = 1'b0; cfg_start = 1'b0;
        check("t6_idle", {busy, done, evt_valid}, 0);
        check("t6_retained", {evt_count, evt_drop}, {8'd1, 1'b1});
        tick();
        check("t6_still_idle", busy, 0);
        // cfg_len=1 promoted to N=2.
        start_cfg(4'd1, 2'b01, 8'd0, 16'd0);
        check("t6_cleared", {evt_count, evt_drop}, {8'd0, 1'b0});
        samp(1'b1);
        check("t6_n2_first", evt_valid, 0);
        samp(1'b1);
        check("t6_n2_evt", {evt_valid, evt_kind, evt_count}, {1'b1, 1'b1, 8'd1});
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        check("t6_stopped", {busy, evt_valid}, 0);

        // Window of 10 alternating samples, gaps not counted, mid-session start ignored.
        start_cfg(4'd4, 2'b10, 8'd0, 16'd10);
        for (int i = 0; i < 10; i++) begin
            samp(logic'(i % 2));
            check($sformatf("t5_done_%0d", i), done, (i == 9) ? 1 : 0);
            if (i == 4) begin
                cfg_window = 16'd3;
                cfg_start  = 1'b1;
            end
            tick();
            cfg_start = 1'b0;
        end
        check("t5_timeout", {timeout, busy, evt_count, evt_valid}, {1'b1, 1'b0, 8'd0, 1'b0});
        tick();
        check("t5_hold", {done, timeout}, {1'b1, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
